// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the N-player scoreboard core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scoreboard_pkg;

    // Game FSM encoding, kept as a 1-bit vector so legacy code can compare raw bits.
    typedef enum logic [0:0] {
        ST_PLAY      = 1'b0,
        ST_GAME_OVER = 1'b1
    } state_e;

    // Width of the winner index: max(1, clog2(n)).
    function automatic int winner_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/scoreboard_press_channel.sv
// One button channel: 2-flop sync, debounce, short/long press classifier.
// Latency: raw edge to debounced level 2 + DEBOUNCE_CYCLES; pulses combinational from registers.
// Backpressure: none; exactly one short or long pulse per accepted hold.
module scoreboard_press_channel #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 25000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_short_o,
    output logic press_long_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    logic [1:0]    sync_q;
    logic          db_q, db_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]    settle_q;
    logic          armed_q, armed_d;
    logic          active_q, active_d;
    logic [HW-1:0] hold_q, hold_d;

    logic mismatch, flip, rise, fall;

    // Debounce edge detection and press classification from registered state.
    always_comb begin
        mismatch      = sync_q[1] ^ db_q;
        flip          = mismatch && (db_cnt_q == DB_LAST);
        rise          = flip && !db_q;
        fall          = flip && db_q;
        press_long_o  = active_q && db_q && (hold_q == HOLD_LAST);
        // A release in the same cycle the long pulse fires is covered by that long pulse.
        press_short_o = fall && active_q && (hold_q < HOLD_LAST);
    end

    // Next-state for debouncer, arming and hold counter.
    always_comb begin
        db_cnt_d = '0;
        if (mismatch && !flip) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
        db_d = flip ? ~db_q : db_q;

        // Only arm once the synchroniser carries the real pin level and shows it released,
        // so a button held across reset never yields a pulse.
        armed_d = armed_q | (settle_q[1] & ~sync_q[1]);

        active_d = active_q;
        if (rise) begin
            active_d = armed_q;
        end else if (fall) begin
            active_d = 1'b0;
        end

        hold_d = hold_q;
        if (!db_q || fall) begin
            hold_d = '0;
        end else if (active_q && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // State registers; reset reads the button as released.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
            settle_q <= '0;
            armed_q  <= 1'b0;
            active_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            settle_q <= {settle_q[0], 1'b1};
            armed_q  <= armed_d;
            active_q <= active_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: rtl/scoreboard_multi_controller.sv
// N-player scoreboard: per-channel press classifiers, score registers, win check, PLAY/GAME_OVER FSM.
// Latency: press pulse T -> score/score_evt at T+1 -> game_over/winner at T+2.
// Backpressure: none; every press pulse is applied or ignored in its own cycle.
module scoreboard_multi_controller
    import scoreboard_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int SCORE_W         = 8,
    parameter int MAX_SCORE       = 99,
    parameter int WIN_SCORE       = 21,
    parameter int WIN_MARGIN      = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 25000000,
    localparam int WINNER_W       = winner_width(NUM_PLAYERS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PLAYERS-1:0]         btn_i,
    input  logic                           new_game_i,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score_o,
    output logic [NUM_PLAYERS-1:0]         score_evt_o,
    output logic                           game_over_o,
    output logic [WINNER_W-1:0]            winner_o
);

    localparam logic [SCORE_W:0] MAX_X    = (SCORE_W+1)'(MAX_SCORE);
    localparam logic [SCORE_W:0] WIN_X    = (SCORE_W+1)'(WIN_SCORE);
    localparam logic [SCORE_W:0] MARGIN_X = (SCORE_W+1)'(WIN_MARGIN);
    localparam logic [SCORE_W:0] ONE_X    = (SCORE_W+1)'(1);

    logic [NUM_PLAYERS-1:0] short_w, long_w;
    logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] evt_q, evt_d;
    state_e                 state_q, state_d;
    logic [WINNER_W-1:0]    winner_q, winner_d;

    logic [NUM_PLAYERS-1:0] win_vec;
    logic [WINNER_W-1:0]    win_idx;
    logic [SCORE_W:0]       sum_x;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_ch
        scoreboard_press_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .btn_i        (btn_i[g]),
            .press_short_o(short_w[g]),
            .press_long_o (long_w[g])
        );
        assign score_o[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    assign score_evt_o = evt_q;
    assign game_over_o = (state_q == ST_GAME_OVER);
    assign winner_o    = winner_q;

    // Win comparator array on registered scores; lowest winning index is selected.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            win_vec[i] = ({1'b0, score_q[i]} >= WIN_X);
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if ((j != i) && ({1'b0, score_q[i]} < ({1'b0, score_q[j]} + MARGIN_X))) begin
                    win_vec[i] = 1'b0;
                end
            end
        end
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (win_vec[i]) begin
                win_idx = WINNER_W'(i);
            end
        end
    end

    // Score updates and FSM transitions; new_game_i overrides any press in the same cycle.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        sum_x    = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_d[i] = score_q[i];
        end

        if (new_game_i) begin
            state_d  = ST_PLAY;
            winner_d = '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_d[i] = '0;
            end
        end else if (state_q == ST_PLAY) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (short_w[i]) begin
                    sum_x      = {1'b0, score_q[i]} + ONE_X;
                    score_d[i] = (sum_x > MAX_X) ? MAX_X[SCORE_W-1:0] : sum_x[SCORE_W-1:0];
                end else if (long_w[i] && (score_q[i] != '0)) begin
                    score_d[i] = score_q[i] - 1'b1;
                end
            end
            if (|win_vec) begin
                state_d  = ST_GAME_OVER;
                winner_d = win_idx;
            end
        end else begin
            // Frozen; only a long press on any channel starts a new game.
            if (|long_w) begin
                state_d  = ST_PLAY;
                winner_d = '0;
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    score_d[i] = '0;
                end
            end
        end

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            evt_d[i] = (score_d[i] != score_q[i]);
        end
    end

    // Score, event, FSM and winner registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= '0;
            end
            evt_q    <= '0;
            state_q  <= ST_PLAY;
            winner_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= score_d[i];
            end
            evt_q    <= evt_d;
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

endmodule

// File: tb/tb_scoreboard_multi_controller.sv
// Self-checking bench for scoreboard_multi_controller (3 players, short debounce/long timings).
// Expected score events are queued as stimulus is driven and checked as the DUT pulses score_evt_o.
// Per-scenario tasks check score/FSM outputs inline.
module tb_scoreboard_multi_controller;

    localparam int NP = 3;
    localparam int SW = 8;

    typedef struct {
        int         ch;
        logic [7:0] val;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [NP-1:0]    btn_i = '0;
    logic             new_game_i = 1'b0;
    logic [NP*SW-1:0] score_o;
    logic [NP-1:0]    score_evt_o;
    logic             game_over_o;
    logic [1:0]       winner_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    scoreboard_multi_controller #(
        .NUM_PLAYERS    (NP),
        .SCORE_W        (SW),
        .MAX_SCORE      (7),
        .WIN_SCORE      (5),
        .WIN_MARGIN     (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .btn_i      (btn_i),
        .new_game_i (new_game_i),
        .score_o    (score_o),
        .score_evt_o(score_evt_o),
        .game_over_o(game_over_o),
        .winner_o   (winner_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: every score_evt_o pulse must match the next queued expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            for (int i = 0; i < NP; i++) begin
                if (score_evt_o[i]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL evt_unexpected: ch%0d pulsed with score %0d, none expected",
                                 i, score_o[i*SW +: SW]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.ch != i || e.val !== score_o[i*SW +: SW]) begin
                            errors++;
                            $display("FAIL evt_match: got ch%0d score %0d, expected ch%0d score %0d",
                                     i, score_o[i*SW +: SW], e.ch, e.val);
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int ch, input int val);
        exp_t e;
        e.ch  = ch;
        e.val = 8'(val);
        exp_q.push_back(e);
    endtask

    // Hold the buttons in mask for the given cycles, release, and let the release settle.
    task automatic press(input logic [NP-1:0] mask, input int cycles);
        btn_i = mask;
        repeat (cycles) @(negedge clk_i);
        btn_i = '0;
        repeat (12) @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if (score_o !== '0 || score_evt_o !== '0 || game_over_o !== 1'b0 || winner_o !== '0) begin
            errors++;
            $display("FAIL reset_vals: score=%h evt=%b go=%b win=%0d, expected all zero",
                     score_o, score_evt_o, game_over_o, winner_o);
        end
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_bounce;
        btn_i = 3'b001; repeat (3) @(negedge clk_i);
        btn_i = 3'b000; repeat (1) @(negedge clk_i);
        btn_i = 3'b001; repeat (3) @(negedge clk_i);
        btn_i = 3'b000; repeat (20) @(negedge clk_i);
        checks++;
        if (score_o !== '0) begin
            errors++;
            $display("FAIL bounce: score=%h, expected 0", score_o);
        end
    endtask

    task automatic test_short_long;
        push(1, 1);
        press(3'b010, 10);
        checks++;
        if (score_o[SW +: SW] !== 8'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL short_press: score1=%0d pending=%0d, expected 1 and 0",
                     score_o[SW +: SW], exp_q.size());
        end
        push(1, 0);
        btn_i = 3'b010;
        repeat (25) @(negedge clk_i);
        checks++;
        if (score_o[SW +: SW] !== 8'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL long_while_held: score1=%0d pending=%0d, expected 0 and 0",
                     score_o[SW +: SW], exp_q.size());
        end
        repeat (15) @(negedge clk_i);
        btn_i = '0;
        repeat (12) @(negedge clk_i);
        checks++;
        if (score_o[SW +: SW] !== 8'd0) begin
            errors++;
            $display("FAIL long_release: score1=%0d, expected 0", score_o[SW +: SW]);
        end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 8; k++) begin
            if (k < 5) push(2, k + 1);
            press(3'b100, 6);
        end
        checks++;
        if (score_o[2*SW +: SW] !== 8'd5 || game_over_o !== 1'b1 || winner_o !== 2'd2) begin
            errors++;
            $display("FAIL win_freeze: score2=%0d go=%b win=%0d, expected 5 1 2",
                     score_o[2*SW +: SW], game_over_o, winner_o);
        end
        push(2, 0);
        new_game_i = 1'b1;
        @(negedge clk_i);
        new_game_i = 1'b0;
        checks++;
        if (score_o !== '0 || game_over_o !== 1'b0 || winner_o !== '0) begin
            errors++;
            $display("FAIL new_game_clear: score=%h go=%b win=%0d, expected 0 0 0",
                     score_o, game_over_o, winner_o);
        end
        for (int k = 0; k < 6; k++) begin
            push(0, k + 1); press(3'b001, 6);
            push(1, k + 1); press(3'b010, 6);
        end
        push(0, 7); press(3'b001, 6);
        press(3'b001, 6);
        checks++;
        if (score_o[0 +: SW] !== 8'd7 || score_o[SW +: SW] !== 8'd6 || game_over_o !== 1'b0) begin
            errors++;
            $display("FAIL saturate: score0=%0d score1=%0d go=%b, expected 7 6 0",
                     score_o[0 +: SW], score_o[SW +: SW], game_over_o);
        end
    endtask

    task automatic test_win_margin;
        bit seen = 0;
        push(0, 6); press(3'b001, 25);
        push(0, 5); press(3'b001, 25);
        push(1, 5); press(3'b010, 25);
        push(1, 4); press(3'b010, 25);
        checks++;
        if (score_o[0 +: SW] !== 8'd5 || score_o[SW +: SW] !== 8'd4 || game_over_o !== 1'b0) begin
            errors++;
            $display("FAIL margin_blocked: score0=%0d score1=%0d go=%b, expected 5 4 0",
                     score_o[0 +: SW], score_o[SW +: SW], game_over_o);
        end
        push(1, 3);
        btn_i = 3'b010;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk_i);
            if (score_evt_o[1]) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL win_evt_timeout: no score_evt_o[1] within 40 cycles");
        end else begin
            checks++;
            if (game_over_o !== 1'b0) begin
                errors++;
                $display("FAIL win_early: go=%b at T+1, expected 0", game_over_o);
            end
            @(negedge clk_i);
            checks++;
            if (game_over_o !== 1'b1 || winner_o !== 2'd0) begin
                errors++;
                $display("FAIL win_latch: go=%b win=%0d at T+2, expected 1 0", game_over_o, winner_o);
            end
        end
        btn_i = '0;
        repeat (12) @(negedge clk_i);
    endtask

    task automatic test_recovery;
        press(3'b100, 6);
        checks++;
        if (score_o[2*SW +: SW] !== 8'd0 || game_over_o !== 1'b1) begin
            errors++;
            $display("FAIL go_short_ignored: score2=%0d go=%b, expected 0 1",
                     score_o[2*SW +: SW], game_over_o);
        end
        push(0, 0);
        push(1, 0);
        press(3'b010, 25);
        checks++;
        if (score_o !== '0 || game_over_o !== 1'b0 || winner_o !== '0) begin
            errors++;
            $display("FAIL go_long_restart: score=%h go=%b win=%0d, expected 0 0 0",
                     score_o, game_over_o, winner_o);
        end
    endtask

    task automatic test_simultaneous;
        bit seen = 0;
        push(0, 1);
        push(2, 1);
        btn_i = 3'b101;
        repeat (8) @(negedge clk_i);
        btn_i = '0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_i);
            if (score_evt_o != '0) seen = 1;
        end
        checks++;
        if (score_evt_o !== 3'b101) begin
            errors++;
            $display("FAIL simul_evt: evt=%b, expected 101", score_evt_o);
        end
        repeat (10) @(negedge clk_i);
        checks++;
        if (score_o !== {8'd1, 8'd0, 8'd1}) begin
            errors++;
            $display("FAIL simul_scores: score=%h, expected 010001", score_o);
        end
    endtask

    task automatic test_new_game_collision;
        btn_i = 3'b001;
        repeat (8) @(negedge clk_i);
        btn_i = '0;
        push(0, 0);
        push(2, 0);
        // The ch0 short pulse lands in the cycle after the fifth rising edge from release.
        repeat (5) @(negedge clk_i);
        new_game_i = 1'b1;
        @(negedge clk_i);
        new_game_i = 1'b0;
        checks++;
        if (score_o !== '0 || game_over_o !== 1'b0) begin
            errors++;
            $display("FAIL ng_priority_t1: score=%h go=%b, expected 0 0", score_o, game_over_o);
        end
        repeat (15) @(negedge clk_i);
        checks++;
        if (score_o !== '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ng_press_dropped: score=%h pending=%0d, expected 0 0", score_o, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_hold;
        btn_i = 3'b001;
        repeat (12) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        btn_i = '0;
        repeat (20) @(negedge clk_i);
        checks++;
        if (score_o !== '0 || game_over_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: score=%h go=%b, expected 0 0", score_o, game_over_o);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_short_long();
        test_saturation();
        test_win_margin();
        test_recovery();
        test_simultaneous();
        test_new_game_collision();
        test_reset_mid_hold();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL evt_missing: %0d expected events never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
